mux3_operand_sequencer: RTL and testbench



---
 rtl/mux3_operand_sequencer.sv | 141 ++++++++++++++
 tb/tb_mux3_operand_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux3_operand_sequencer.sv
// Operand sequencer for a 3-bit 2:1 select stage: loads X0/X1 over valid/ready,
// then alternates S for ROUNDS pairs of HOLD cycles. Optional macro: MUX_SEQ_REPEAT_EN.
module mux3_operand_sequencer #(
  parameter int HOLD   = 4,
  parameter int ROUNDS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [2:0] X0,
  output logic [2:0] X1,
  output logic       S,
  output logic       sel_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] HOLD_LAST  = 4'(HOLD - 1);
  localparam logic [3:0] ROUND_LAST = 4'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [2:0] x0_q, x0_d;
  logic [2:0] x1_q, x1_d;
  logic       s_q, s_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic       xfer;

  // Handshake outputs decode state only, so din_ready never depends on din_valid.
  assign din_ready = (state_q == ST_LOAD0) || (state_q == ST_LOAD1);
  assign sel_valid = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign xfer      = din_valid && din_ready;

  assign X0 = x0_q;
  assign X1 = x1_q;
  assign S  = s_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    s_d         = s_q;
    hold_cnt_d  = hold_cnt_q;
    round_cnt_d = round_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD0;
      end

      ST_LOAD0: begin
        if (xfer) begin
          x0_d    = din;
          state_d = ST_LOAD1;
        end
      end

      ST_LOAD1: begin
        if (xfer) begin
          x1_d        = din;
          s_d         = 1'b0;
          hold_cnt_d  = 4'd0;
          round_cnt_d = 4'd0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        hold_cnt_d = hold_cnt_q + 4'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = 4'd0;
          s_d        = ~s_q;
          // A round ends on the expiry of the S=1 half.
          if (s_q) begin
            round_cnt_d = round_cnt_q + 4'd1;
            if (round_cnt_q == ROUND_LAST) begin
              s_d     = 1'b0;
              state_d = ST_DONE;
            end
          end
        end
`ifdef MUX_SEQ_REPEAT_EN
        // Abort outranks the end-of-run transition, so no done pulse follows.
        if (start) begin
          s_d         = 1'b0;
          hold_cnt_d  = 4'd0;
          round_cnt_d = 4'd0;
          state_d     = ST_LOAD0;
        end
`endif
      end

      ST_DONE: begin
`ifdef MUX_SEQ_REPEAT_EN
        s_d         = 1'b0;
        hold_cnt_d  = 4'd0;
        round_cnt_d = 4'd0;
        state_d     = start ? ST_LOAD0 : ST_RUN;
`else
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so all flops see pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x0_q        <= 3'b000;
      x1_q        <= 3'b000;
      s_q         <= 1'b0;
      hold_cnt_q  <= 4'd0;
      round_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      s_q         <= s_d;
      hold_cnt_q  <= hold_cnt_d;
      round_cnt_q <= round_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux3_operand_sequencer.sv
// Self-checking bench for mux3_operand_sequencer; expected outputs come from a
// schedule model (S = (k/HOLD) mod 2 over 2*HOLD*ROUNDS RUN cycles).
module tb_mux3_operand_sequencer;

`ifdef MUX_SEQ_REPEAT_EN
  localparam int H = 1;
  localparam int R = 1;
`else
  localparam int H = 2;
  localparam int R = 2;
`endif
  localparam int RUN_LEN = 2 * H * R;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [2:0] x0, x1;
  logic       s;
  logic       sel_valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] m_x0 = 3'b000;
  logic [2:0] m_x1 = 3'b000;

  always #5 clk = ~clk;

  mux3_operand_sequencer #(.HOLD(H), .ROUNDS(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .X0        (x0),
    .X1        (x1),
    .S         (s),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed compare {X0,X1,S,din_ready,sel_valid,busy,done}; S may be excluded.
  task automatic expect_outs(input string tag, input logic [2:0] ex0, input logic [2:0] ex1,
                             input logic es, input logic erdy, input logic esv,
                             input logic ebusy, input logic edone, input logic s_care);
    logic [31:0] got, exp;
    got = {21'd0, x0, x1, (s_care ? s : 1'b0), din_ready, sel_valid, busy, done};
    exp = {21'd0, ex0, ex1, (s_care ? es : 1'b0), erdy, esv, ebusy, edone};
    check(tag, got, exp);
  endtask

  function automatic logic sched_s(input int k);
    return logic'((k / H) % 2);
  endfunction

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0; start = 1'b1; din = 3'b111; din_valid = 1'b1;
    repeat (cycles) step();
    m_x0 = 3'b000; m_x1 = 3'b000;
    expect_outs("reset", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1; start = 1'b0;
  endtask

  // Starting in LOAD0: transfer word a, wait gap cycles, transfer b; ends in RUN cycle 0.
  task automatic load_words(input logic [2:0] a, input logic [2:0] b, input int gap);
    expect_outs("load0", m_x0, m_x1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    din = a; din_valid = 1'b1;
    step();
    m_x0 = a;
    expect_outs("load1", m_x0, m_x1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) begin
      din = 3'($urandom); din_valid = 1'b0;
      step();
      expect_outs("backpressure", m_x0, m_x1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    din = b; din_valid = 1'b1;
    step();
    m_x1 = b;
  endtask

`ifndef MUX_SEQ_REPEAT_EN
  // One complete run from IDLE; start_at/rst_at select a RUN cycle (or -1).
  task automatic run_seq(input logic [2:0] a, input logic [2:0] b, input int gap,
                         input int start_at, input int rst_at);
    start = 1'b1; din = 3'($urandom); din_valid = 1'($urandom);
    step();
    start = 1'b0;
    load_words(a, b, gap);
    for (int k = 0; k < RUN_LEN; k++) begin
      expect_outs($sformatf("run k=%0d", k), m_x0, m_x1, sched_s(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      din = 3'($urandom); din_valid = 1'($urandom);
      start = (k == start_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        step();
        m_x0 = 3'b000; m_x1 = 3'b000;
        expect_outs("reset mid-run", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1; start = 1'b0;
        return;
      end
      step();
    end
    start = 1'b0;
    expect_outs("done pulse", m_x0, m_x1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    expect_outs("back to idle", m_x0, m_x1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; din = 3'($urandom); din_valid = 1'($urandom);
      step();
      expect_outs("idle ignores din", m_x0, m_x1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask
`endif

  initial begin
    start = 1'b0; din = 3'b000; din_valid = 1'b0; rst_n = 1'b0;
    apply_reset(2);

`ifndef MUX_SEQ_REPEAT_EN
    idle_cycles(2);
    run_seq(3'b101, 3'b010, 0, -1, -1);
    idle_cycles(1);
    run_seq(3'b110, 3'b001, 3, -1, -1);
    run_seq(3'b011, 3'b100, 0, 3, -1);
    run_seq(3'b111, 3'b010, 1, -1, 6);
    idle_cycles(2);
    for (int it = 0; it < 20; it++) begin
      int gap, sa, ra;
      gap = int'($urandom_range(0, 3));
      sa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, RUN_LEN - 1)) : -1;
      ra  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, RUN_LEN - 1)) : -1;
      run_seq(3'($urandom), 3'($urandom), gap, sa, ra);
      idle_cycles(int'($urandom_range(0, 2)));
    end
`else
    start = 1'b1; din_valid = 1'b0;
    step();
    start = 1'b0;
    load_words(3'b101, 3'b010, 2);
    for (int c = 0; c < 3 * (RUN_LEN + 1); c++) begin
      int p;
      p = c % (RUN_LEN + 1);
      if (p < RUN_LEN)
        expect_outs($sformatf("repeat run c=%0d", c), m_x0, m_x1, sched_s(p), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      else
        expect_outs($sformatf("repeat done c=%0d", c), m_x0, m_x1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      din_valid = 1'($urandom);
      step();
    end
    expect_outs("repeat run before abort", m_x0, m_x1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_outs("abort to load0", m_x0, m_x1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    load_words(3'b011, 3'b100, 0);
    for (int k = 0; k <= RUN_LEN; k++) begin
      if (k < RUN_LEN)
        expect_outs("reloaded run", m_x0, m_x1, sched_s(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      else
        expect_outs("reloaded done", m_x0, m_x1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      step();
    end
    apply_reset(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
